// File: rtl/st7920_fb_driver.sv
`default_nettype none
// ============================================================================
// Module      : st7920_fb_driver
// Description : Streams a byte framebuffer to an ST7920 128x64 graphic LCD
//               over its 8-bit parallel bus. Runs the power-up init
//               sequence, then refreshes row by row on request or
//               continuously. All timing comes from a step counter in the
//               single clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module st7920_fb_driver #(
    parameter int CLK_DIV    = 50,
    parameter int ROWS       = 32,
    parameter int ADDR_W     = 10,
    parameter int CLEAR_WAIT = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        fb_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic [7:0]        lcd_dat
);

    localparam int c_CNT_W  = $clog2(2 * CLK_DIV);
    localparam int c_WAIT_W = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;

    localparam logic [c_CNT_W-1:0]  c_STEP_LAST = c_CNT_W'(2 * CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_EN_RISE   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(CLEAR_WAIT - 1);
    localparam logic [5:0]          c_ROW_LAST  = 6'(ROWS - 1);

    // The state names the bus transfer that is launched at the next step
    // boundary; the step right after reset is therefore a silent lead-in.
    localparam logic [3:0] c_INIT_FN   = 4'd0;
    localparam logic [3:0] c_INIT_DISP = 4'd1;
    localparam logic [3:0] c_INIT_CLR  = 4'd2;
    localparam logic [3:0] c_CLR_WAIT  = 4'd3;
    localparam logic [3:0] c_INIT_GFX  = 4'd4;
    localparam logic [3:0] c_IDLE      = 4'd5;
    localparam logic [3:0] c_SET_Y     = 4'd6;
    localparam logic [3:0] c_SET_X     = 4'd7;
    localparam logic [3:0] c_DATA_HI   = 4'd8;
    localparam logic [3:0] c_DATA_LO   = 4'd9;

    logic [3:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [5:0]          r_row;
    logic [2:0]          r_col;
    logic                r_active;     // current step carries a transfer
    logic                r_frame_end;  // last byte of the frame is on the bus
    logic                r_req;        // start seen while idle, awaiting a boundary
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rs;
    logic                r_en;
    logic [7:0]          r_dat;

    logic w_step_end;
    assign w_step_end = (r_cnt == c_STEP_LAST);

    assign busy       = r_busy;
    assign frame_done = r_done;
    assign fb_addr    = r_addr;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_en;
    assign lcd_dat    = r_dat;

    // Step timing, init sequencing and frame streaming; bus fields only move
    // on a step boundary while lcd_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_INIT_FN;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_active    <= 1'b0;
            r_frame_end <= 1'b0;
            r_req       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_dat       <= 8'h00;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_step_end ? '0 : r_cnt + 1'b1;
            // Starts are only remembered while idle; requests during a frame
            // are dropped rather than queued.
            if (start && r_state == c_IDLE)
                r_req <= 1'b1;
            if (r_cnt == c_EN_RISE && r_active)
                r_en <= 1'b1;
            if (w_step_end) begin
                r_en     <= 1'b0;
                r_active <= 1'b0;
                case (r_state)
                    c_INIT_FN: begin
                        r_rs <= 1'b0; r_dat <= 8'h30; r_active <= 1'b1;
                        r_state <= c_INIT_DISP;
                    end
                    c_INIT_DISP: begin
                        r_rs <= 1'b0; r_dat <= 8'h0C; r_active <= 1'b1;
                        r_state <= c_INIT_CLR;
                    end
                    c_INIT_CLR: begin
                        r_rs <= 1'b0; r_dat <= 8'h01; r_active <= 1'b1;
                        r_wait  <= '0;
                        r_state <= c_CLR_WAIT;
                    end
                    c_CLR_WAIT: begin
                        r_wait <= r_wait + 1'b1;
                        if (r_wait == c_WAIT_LAST)
                            r_state <= c_INIT_GFX;
                    end
                    c_INIT_GFX: begin
                        r_rs <= 1'b0; r_dat <= 8'h36; r_active <= 1'b1;
                        r_state <= c_IDLE;
                    end
                    c_IDLE: begin
                        if (r_req || continuous) begin
                            r_req  <= 1'b0;
                            r_busy <= 1'b1;
                            r_rs <= 1'b0; r_dat <= 8'h80; r_active <= 1'b1;
                            r_state <= c_SET_X;
                        end
                    end
                    c_SET_Y: begin
                        if (r_frame_end) begin
                            r_frame_end <= 1'b0;
                            r_done      <= 1'b1;
                            if (continuous) begin
                                r_rs <= 1'b0; r_dat <= 8'h80; r_active <= 1'b1;
                                r_state <= c_SET_X;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_rs <= 1'b0; r_dat <= {3'b100, r_row[4:0]}; r_active <= 1'b1;
                            r_state <= c_SET_X;
                        end
                    end
                    c_SET_X: begin
                        r_rs <= 1'b0; r_dat <= r_row[5] ? 8'h88 : 8'h80; r_active <= 1'b1;
                        r_state <= c_DATA_HI;
                    end
                    c_DATA_HI: begin
                        r_rs <= 1'b1; r_dat <= fb_data; r_active <= 1'b1;
                        r_addr  <= r_addr + 1'b1;
                        r_state <= c_DATA_LO;
                    end
                    c_DATA_LO: begin
                        r_rs <= 1'b1; r_dat <= fb_data; r_active <= 1'b1;
                        if (r_col == 3'd7) begin
                            r_col   <= '0;
                            r_state <= c_SET_Y;
                            if (r_row == c_ROW_LAST) begin
                                r_row       <= '0;
                                r_addr      <= '0;
                                r_frame_end <= 1'b1;
                            end else begin
                                r_row  <= r_row + 1'b1;
                                r_addr <= r_addr + 1'b1;
                            end
                        end else begin
                            r_col   <= r_col + 1'b1;
                            r_addr  <= r_addr + 1'b1;
                            r_state <= c_DATA_HI;
                        end
                    end
                    default: r_state <= c_INIT_FN;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_st7920_fb_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_st7920_fb_driver
// Description : Scoreboard bench for st7920_fb_driver. Expected bus
//               transfers are queued as stimulus is applied and matched
//               against transfers captured on each lcd_en pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_st7920_fb_driver;

    localparam int CLK_DIV = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;
    int viol       = 0;

    logic rst32 = 1'b1, start32 = 1'b0, cont32 = 1'b0;
    logic busy32, fd32, rs32, rw32, en32;
    logic [9:0] addr32;
    logic [7:0] fbd32, dat32;
    logic [7:0] mem32 [1024];

    logic rst64 = 1'b1, start64 = 1'b0, cont64 = 1'b0;
    logic busy64, fd64, rs64, rw64, en64;
    logic [9:0] addr64;
    logic [7:0] fbd64, dat64;
    logic [7:0] mem64 [1024];

    st7920_fb_driver #(.CLK_DIV(CLK_DIV), .ROWS(32), .ADDR_W(10), .CLEAR_WAIT(3)) dut (
        .clk(clk), .reset(rst32), .start(start32), .continuous(cont32),
        .busy(busy32), .frame_done(fd32), .fb_addr(addr32), .fb_data(fbd32),
        .lcd_rs(rs32), .lcd_rw(rw32), .lcd_en(en32), .lcd_dat(dat32));

    st7920_fb_driver #(.CLK_DIV(CLK_DIV), .ROWS(64), .ADDR_W(10), .CLEAR_WAIT(3)) dut64 (
        .clk(clk), .reset(rst64), .start(start64), .continuous(cont64),
        .busy(busy64), .frame_done(fd64), .fb_addr(addr64), .fb_data(fbd64),
        .lcd_rs(rs64), .lcd_rw(rw64), .lcd_en(en64), .lcd_dat(dat64));

    // Synchronous framebuffer RAMs
    always @(posedge clk) fbd32 <= mem32[addr32];
    always @(posedge clk) fbd64 <= mem64[addr64];

    // Scoreboard queues: {rs, dat}
    logic [8:0]  exp32[$], obs32[$], exp64[$], obs64[$];
    int unsigned t32[$], fd_t32[$];
    logic        fd_busy32[$];
    int          fd_cnt32 = 0, fd_cnt64 = 0;

    // Monitors: capture a transfer at each en rise, check bus stability and pulse width
    logic pen32 = 0, prs32 = 0, pen64 = 0, prs64 = 0;
    logic [7:0] pdat32 = 0, pdat64 = 0;
    int len32 = 0, len64 = 0;

    always @(negedge clk) begin
        if (en32 && !pen32) begin
            obs32.push_back({rs32, dat32});
            t32.push_back(cyc);
        end
        if (en32 && pen32 && ({rs32, dat32} !== {prs32, pdat32})) viol++;
        if (!rst32 && !en32 && pen32 && len32 != CLK_DIV) viol++;
        len32 = en32 ? len32 + 1 : 0;
        if (fd32) begin
            fd_cnt32++;
            fd_t32.push_back(cyc);
            fd_busy32.push_back(busy32);
        end
        pen32 = en32; prs32 = rs32; pdat32 = dat32;
    end

    always @(negedge clk) begin
        if (en64 && !pen64) obs64.push_back({rs64, dat64});
        if (en64 && pen64 && ({rs64, dat64} !== {prs64, pdat64})) viol++;
        if (!rst64 && !en64 && pen64 && len64 != CLK_DIV) viol++;
        len64 = en64 ? len64 + 1 : 0;
        if (fd64) fd_cnt64++;
        pen64 = en64; prs64 = rs64; pdat64 = dat64;
    end

    task automatic clear32();
        exp32.delete(); obs32.delete(); t32.delete();
        fd_t32.delete(); fd_busy32.delete(); fd_cnt32 = 0;
    endtask

    task automatic wait_obs32(input int n, input int limit, input string name);
        int k;
        for (k = 0; k < limit && obs32.size() < n; k++) @(posedge clk);
        if (obs32.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got %0d transfers, required %0d", name, obs32.size(), n);
        end
    endtask

    task automatic wait_fd32(input int n, input int limit, input string name);
        int k;
        for (k = 0; k < limit && fd_cnt32 < n; k++) @(posedge clk);
        if (fd_cnt32 < n) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: got %0d frame_done, required %0d", name, fd_cnt32, n);
        end
    endtask

    task automatic push_frame32();
        for (int r = 0; r < 32; r++) begin
            exp32.push_back({1'b0, 8'h80 | 8'(r)});
            exp32.push_back({1'b0, 8'h80});
            for (int b = 0; b < 16; b++) exp32.push_back({1'b1, mem32[r*16+b]});
        end
    endtask

    task automatic push_init32();
        exp32.push_back({1'b0, 8'h30});
        exp32.push_back({1'b0, 8'h0C});
        exp32.push_back({1'b0, 8'h01});
        exp32.push_back({1'b0, 8'h36});
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        vectors++;
        if ({busy32, fd32, addr32, rs32, rw32, en32, dat32} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset32: got busy=%b fd=%b addr=%0d rs=%b rw=%b en=%b dat=%02h, required all zero",
                     busy32, fd32, addr32, rs32, rw32, en32, dat32);
        end
        vectors++;
        if ({busy64, fd64, addr64, rs64, rw64, en64, dat64} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset64: got busy=%b en=%b addr=%0d dat=%02h, required all zero",
                     busy64, en64, addr64, dat64);
        end
        rst32 = 1'b0; rst64 = 1'b0;
    endtask

    task automatic test_init();
        int unsigned tt[4];
        logic [8:0] o, e;
        clear32();
        push_init32();
        wait_obs32(4, 300, "init");
        for (int i = 0; i < 4 && obs32.size() > 0; i++) begin
            o = obs32.pop_front(); e = exp32.pop_front(); tt[i] = t32.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL init[%0d]: got %03h required %03h", i, o, e);
            end
        end
        vectors++;
        if (tt[1] - tt[0] != 4) begin
            miscompares++;
            $display("FAIL init_step: got %0d clk required 4", tt[1] - tt[0]);
        end
        vectors++;
        if (tt[3] - tt[2] != 16) begin
            miscompares++;
            $display("FAIL clear_wait: got %0d clk required 16", tt[3] - tt[2]);
        end
        repeat (60) @(negedge clk);
        vectors++;
        if (obs32.size() != 0 || busy32 !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_init: got %0d transfers busy=%b, required 0 and 0", obs32.size(), busy32);
        end
    endtask

    task automatic test_frame();
        logic [8:0] o, e;
        int unsigned t0;
        clear32();
        push_frame32();
        @(negedge clk) start32 = 1'b1;
        @(negedge clk) start32 = 1'b0;
        repeat (50) @(negedge clk);
        vectors++;
        if (busy32 !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_frame: got %b required 1", busy32);
        end
        start32 = 1'b1; @(negedge clk) start32 = 1'b0;
        wait_obs32(570, 3000, "frame");
        start32 = 1'b1; @(negedge clk) start32 = 1'b0;
        wait_fd32(1, 200, "frame_done");
        repeat (200) @(negedge clk);
        vectors++;
        if (fd_cnt32 != 1 || obs32.size() != 576) begin
            miscompares++;
            $display("FAIL frame_count: got %0d done %0d transfers, required 1 done 576 transfers",
                     fd_cnt32, obs32.size());
        end
        t0 = t32[0];
        for (int i = 0; i < 576 && obs32.size() > 0; i++) begin
            o = obs32.pop_front(); e = exp32.pop_front(); void'(t32.pop_front());
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL frame[%0d] row %0d: got %03h required %03h", i, i / 18, o, e);
            end
        end
        if (fd_t32.size() > 0) begin
            vectors++;
            if (fd_t32[0] - t0 != 2302) begin
                miscompares++;
                $display("FAIL frame_len: got %0d clk required 2302", fd_t32[0] - t0);
            end
            vectors++;
            if (fd_busy32[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_at_done: got %b required 0", fd_busy32[0]);
            end
        end
        vectors++;
        if (busy32 !== 1'b0 || addr32 !== 10'd0) begin
            miscompares++;
            $display("FAIL after_frame: got busy=%b addr=%0d required 0 0", busy32, addr32);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] o, e;
        clear32();
        push_frame32();
        push_frame32();
        @(negedge clk) cont32 = 1'b1;
        wait_fd32(1, 3000, "cont_first");
        repeat (100) @(negedge clk);
        cont32 = 1'b0;
        start32 = 1'b1; @(negedge clk) start32 = 1'b0;
        wait_fd32(2, 3000, "cont_second");
        repeat (200) @(negedge clk);
        vectors++;
        if (fd_cnt32 != 2 || obs32.size() != 1152) begin
            miscompares++;
            $display("FAIL cont_count: got %0d done %0d transfers, required 2 done 1152 transfers",
                     fd_cnt32, obs32.size());
        end
        if (fd_t32.size() >= 2) begin
            vectors++;
            if (fd_t32[1] - fd_t32[0] != 2304) begin
                miscompares++;
                $display("FAIL cont_gap: got %0d clk required 2304", fd_t32[1] - fd_t32[0]);
            end
        end
        for (int i = 0; i < 1152 && obs32.size() > 0; i++) begin
            o = obs32.pop_front(); e = exp32.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL cont[%0d]: got %03h required %03h", i, o, e);
            end
        end
        vectors++;
        if (busy32 !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_idle: got busy=%b required 0", busy32);
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] o, e;
        clear32();
        @(negedge clk) start32 = 1'b1;
        @(negedge clk) start32 = 1'b0;
        wait_obs32(100, 1000, "mid_frame");
        @(negedge clk) rst32 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy32, fd32, en32, rs32, addr32, dat32} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b fd=%b en=%b rs=%b addr=%0d dat=%02h, required all zero",
                     busy32, fd32, en32, rs32, addr32, dat32);
        end
        repeat (3) @(negedge clk);
        rst32 = 1'b0;
        clear32();
        push_init32();
        wait_obs32(4, 300, "reinit");
        for (int i = 0; i < 4 && obs32.size() > 0; i++) begin
            o = obs32.pop_front(); e = exp32.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reinit[%0d]: got %03h required %03h", i, o, e);
            end
        end
        repeat (40) @(negedge clk);
        vectors++;
        if (busy32 !== 1'b0 || obs32.size() != 0) begin
            miscompares++;
            $display("FAIL reinit_idle: got busy=%b %0d transfers, required 0 0", busy32, obs32.size());
        end
    endtask

    task automatic test_rows64();
        logic [8:0] o, e;
        int k;
        obs64.delete(); exp64.delete(); fd_cnt64 = 0;
        for (int r = 0; r < 64; r++) begin
            exp64.push_back({1'b0, 8'h80 | 8'(r % 32)});
            exp64.push_back({1'b0, (r < 32) ? 8'h80 : 8'h88});
            for (int b = 0; b < 16; b++) exp64.push_back({1'b1, mem64[r*16+b]});
        end
        @(negedge clk) start64 = 1'b1;
        @(negedge clk) start64 = 1'b0;
        for (k = 0; k < 6000 && fd_cnt64 < 1; k++) @(posedge clk);
        repeat (40) @(negedge clk);
        vectors++;
        if (fd_cnt64 != 1 || obs64.size() != 1152) begin
            miscompares++;
            $display("FAIL rows64_count: got %0d done %0d transfers, required 1 done 1152 transfers",
                     fd_cnt64, obs64.size());
        end
        for (int i = 0; i < 1152 && obs64.size() > 0; i++) begin
            o = obs64.pop_front(); e = exp64.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rows64[%0d] row %0d: got %03h required %03h", i, i / 18, o, e);
            end
        end
    endtask

    task automatic test_bus_timing();
        vectors++;
        if (viol != 0 || rw32 !== 1'b0 || rw64 !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_timing: got %0d violations rw=%b/%b, required 0 and rw=0", viol, rw32, rw64);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem32[i] = 8'(i);
            mem64[i] = 8'(i * 37 + 11);
        end
        test_reset();
        test_init();
        test_frame();
        test_back_to_back();
        test_reset_midframe();
        test_rows64();
        test_bus_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/st7920_fb_driver.md
ST7920_FB_DRIVER -- requirements
Module: st7920_fb_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per half LCD step (en low half, en high half).
REQ-002 SHALL have parameter ROWS, default 32, meaning panel rows refreshed per frame; legal values are 32 and 64 only.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning framebuffer address width; must satisfy 2^ADDR_W >= ROWS*16.
REQ-004 SHALL have parameter CLEAR_WAIT, default 20, meaning idle LCD steps inserted after the CLEAR command.
REQ-005 SHALL have port clk  input  1  system clock; the block uses one clock and all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  single-frame refresh request, sampled every clk.
REQ-008 SHALL have port continuous  input  1  when 1, a new frame starts automatically after each frame.
REQ-009 SHALL have port busy  output  1  high from frame acceptance until frame completion.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse at frame completion.
REQ-011 SHALL have port fb_addr  output  ADDR_W  framebuffer byte address.
REQ-012 SHALL have port fb_data  input  8  framebuffer byte, valid 1 clk after fb_addr (synchronous RAM).
REQ-013 SHALL have ports lcd_rs, lcd_rw, lcd_en (output, 1 bit each) and lcd_dat (output, 8 bits), forming the ST7920 parallel bus.

Function
REQ-014 SHALL generate a step-enable from a CLK_DIV counter in the clk domain; no derived clocks.
REQ-015 Each LCD step SHALL last 2*CLK_DIV clk cycles: lcd_en is 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles; lcd_rs and lcd_dat change only on the first clk of a step.
REQ-016 lcd_rw SHALL be constant 0.
REQ-017 The FSM SHALL have states INIT_FN, INIT_DISP, INIT_CLR, CLR_WAIT, INIT_GFX, IDLE, SET_Y, SET_X, DATA_HI, DATA_LO, and each state transition SHALL occur only on a step boundary.
REQ-018 The init sequence SHALL send commands (rs=0) 0x30, 0x0C, 0x01, then hold lcd_en=0 for CLEAR_WAIT steps, then send 0x36, then enter IDLE.
REQ-019 In IDLE, start=1 or continuous=1 SHALL accept a frame at the next step boundary; start pulses while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-020 Each frame SHALL iterate rows r=0..ROWS-1 and word columns w=0..7.
REQ-021 For each row, the FSM SHALL send a SET_Y command with value 0x80|(r mod 32).
REQ-022 For each row, the FSM SHALL send a SET_X command with value 0x80 for r<32, or 0x88 for r>=32.
REQ-023 After SET_Y and SET_X, the FSM SHALL send 16 data bytes (rs=1) alternating DATA_HI/DATA_LO.
REQ-024 The data byte for row r, byte b (0..15) SHALL be fb_data read at fb_addr=r*16+b.
REQ-025 fb_addr SHALL be driven at least 2 clk before the step in which its byte is placed on lcd_dat.
REQ-026 A frame SHALL be ROWS*18 steps long.
REQ-027 After the last DATA_LO of row ROWS-1, frame_done SHALL pulse for 1 clk on the step boundary; busy SHALL fall on the same clk; fb_addr SHALL wrap to 0.
REQ-028 After frame_done, the FSM SHALL go to SET_Y of row 0 if continuous=1, otherwise to IDLE.
REQ-029 Row and column counters SHALL wrap without overflow into fb_addr; row counter width SHALL be 6 bits.
REQ-030 A rising continuous mid-frame SHALL NOT alter the current frame.
REQ-031 Deasserting continuous mid-frame SHALL let the current frame complete, after which the FSM goes to IDLE.

Reset
REQ-032 reset=1 at any clk, including mid-frame or mid-init, SHALL on that edge force state INIT_FN, step counter to 0, and outputs to: busy=0, frame_done=0, fb_addr=0, lcd_rs=0, lcd_en=0, lcd_dat=0x00.
REQ-033 After reset, the full init sequence SHALL repeat before any frame is accepted.

Verification
REQ-034 Reset release with CLK_DIV=2 and CLEAR_WAIT=3 -> lcd_dat sequence 0x30, 0x0C, 0x01 at rs=0, each with one en high pulse of 2 clk; then 3 steps with no en pulse; then 0x36; then IDLE with busy=0.
REQ-035 ROWS=32, fb[i]=i[7:0], one start pulse -> per row: 0x80|r, 0x80, then bytes 16r..16r+15 at rs=1; 576 steps in total; frame_done pulses exactly once; busy falls on the same clk.
REQ-036 ROWS=64 -> row 40 sends SET_Y 0x88 and SET_X 0x88, with data from fb_addr 640..655.
REQ-037 continuous=1 for 2 frames, then 0 -> back-to-back frames with no IDLE step between them, 2 frame_done pulses, IDLE after the 2nd frame; start pulses issued during busy produce no extra frame.
REQ-038 reset asserted at step 100 of a frame -> next clk shows busy=0, lcd_en=0, fb_addr=0; init sequence restarts.
REQ-039 Bus-timing checker across all tests -> lcd_rs and lcd_dat never change while lcd_en=1.
